// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller between the timer/external request lines and
// the CPU interrupt input. Per-source pending latches (edge or level), enables,
// global enable, priority select and a request/ack/EOI handshake with the CPU.
//
// Build option: define IRQ_ROTATE_EN for round-robin priority starting after
// the last acknowledged source (last_id, readable in STAT[18:16]). Without it,
// source 0 has the highest fixed priority and STAT[18:16] reads 0.
//
// Register map (addr[3:2]):
//   0x0 PEND  R, W1C on byteen[0] (edge-mode bits only)
//   0x4 IE    RW on byteen[0]
//   0x8 CTRL  bit0 GIE on byteen[0]; EDGE at [8+N_SRC-1:8] on byteen[1]
//   0xC STAT  {last_id[18:16], state[9:8], isr_id[2:0]}; write with byteen[0] = EOI
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no request outstanding; waits for an enabled pending source
// REQ     | irq_out high; isr_id tracks the current winner until ack
// SERVICE | CPU is handling isr_id; no new request until EOI

module irq_ctrl #(
    parameter int N_SRC = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [3:0]       byteen,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             irq_out,
    output logic [2:0]       irq_id,
    input  logic             irq_ack
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_REQ     = 2'b01,
        S_SERVICE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] src_q, src_qq;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] ie_q, ie_d;
    logic [N_SRC-1:0] edge_mode_q, edge_mode_d;
    logic             gie_q, gie_d;
    logic [2:0]       isr_id_q, isr_id_d;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] req_vec;
    logic [2:0]       winner;
    logic [1:0]       reg_sel;
    logic             wr_b0, wr_b1;
    logic             ack_take;
    logic             eoi;
    logic             unused_bits;

    assign reg_sel  = addr[3:2];
    assign wr_b0    = byteen[0];
    assign wr_b1    = byteen[1];
    assign rise     = src_q & ~src_qq;
    assign req_vec  = gie_q ? (pend_q & ie_q) : '0;
    assign ack_take = (state_q == S_REQ) && irq_ack;
    assign eoi      = (state_q == S_SERVICE) && wr_b0 && (reg_sel == 2'd3);

    // Address bits outside [3:2], upper byte enables and most of wdata are not decoded.
    assign unused_bits = ^{addr[31:4], addr[1:0], byteen[3:2], wdata};

`ifdef IRQ_ROTATE_EN
    logic [2:0]       last_id_q, last_id_d;
    logic [2:0]       start_id;
    logic [N_SRC-1:0] req_rot;
    int               rot_off;

    assign start_id  = (last_id_q >= 3'(N_SRC - 1)) ? 3'd0 : last_id_q + 3'd1;
    assign req_rot   = N_SRC'({req_vec, req_vec} >> start_id);
    assign last_id_d = ack_take ? isr_id_q : last_id_q;

    // Round-robin winner: first requester at or after start_id, wrapping.
    always_comb begin
        rot_off = 0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (req_rot[k]) rot_off = k;
        end
        rot_off = rot_off + int'(start_id);
        if (rot_off >= N_SRC) rot_off = rot_off - N_SRC;
        winner = 3'(rot_off);
    end

    // Last acknowledged source, the reference point for the next search.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_id_q <= '0;
        else       last_id_q <= last_id_d;
    end
`else
    // Fixed-priority winner: lowest set index of req_vec.
    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_vec[i]) winner = 3'(i);
        end
    end
`endif

    // Pending latches: edge bits set on a rise (set beats clears), level bits follow the input.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < N_SRC; i++) begin
            if (edge_mode_q[i]) begin
                if (wr_b0 && (reg_sel == 2'd0) && wdata[i]) pend_d[i] = 1'b0;
                if (ack_take && (isr_id_q == 3'(i)))        pend_d[i] = 1'b0;
                if (rise[i])                                 pend_d[i] = 1'b1;
            end else begin
                pend_d[i] = src_q[i];
            end
        end
    end

    // Configuration register writes.
    always_comb begin
        ie_d        = ie_q;
        gie_d       = gie_q;
        edge_mode_d = edge_mode_q;
        if (wr_b0 && (reg_sel == 2'd1)) ie_d        = wdata[N_SRC-1:0];
        if (wr_b0 && (reg_sel == 2'd2)) gie_d       = wdata[0];
        if (wr_b1 && (reg_sel == 2'd2)) edge_mode_d = wdata[8 +: N_SRC];
    end

    // Next-state and in-service id; ack wins over a request that has just vanished.
    always_comb begin
        state_d  = state_q;
        isr_id_d = isr_id_q;
        case (state_q)
            S_IDLE: begin
                if (|req_vec) begin
                    state_d  = S_REQ;
                    isr_id_d = winner;
                end
            end
            S_REQ: begin
                if (irq_ack)            state_d  = S_SERVICE;
                else if (req_vec == '0) state_d  = S_IDLE;
                else                    isr_id_d = winner;
            end
            S_SERVICE: begin
                if (eoi) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Input synchronisers, pending/config registers and in-service id.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q       <= '0;
            src_qq      <= '0;
            pend_q      <= '0;
            ie_q        <= '0;
            edge_mode_q <= '0;
            gie_q       <= 1'b0;
            isr_id_q    <= '0;
        end else begin
            src_q       <= irq_src;
            src_qq      <= src_q;
            pend_q      <= pend_d;
            ie_q        <= ie_d;
            edge_mode_q <= edge_mode_d;
            gie_q       <= gie_d;
            isr_id_q    <= isr_id_d;
        end
    end

    // CPU-facing outputs decoded from the state register.
    always_comb begin
        irq_out = (state_q == S_REQ);
        irq_id  = isr_id_q;
    end

    // Read mux; unimplemented bits return 0.
    always_comb begin
        rdata = '0;
        case (reg_sel)
            2'd0: rdata[N_SRC-1:0] = pend_q;
            2'd1: rdata[N_SRC-1:0] = ie_q;
            2'd2: begin
                rdata[0]          = gie_q;
                rdata[8 +: N_SRC] = edge_mode_q;
            end
            default: begin
                rdata[9:8] = state_q;
                rdata[2:0] = isr_id_q;
`ifdef IRQ_ROTATE_EN
                rdata[18:16] = last_id_q;
`endif
            end
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl: table-driven register vectors followed by
// hand-written handshake sequences, all checked through an expectation queue.

module tb_irq_ctrl;

    localparam int N = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  irq_src;
    logic [3:0]    byteen;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          irq_out;
    logic [2:0]    irq_id;
    logic          irq_ack;

    always #5 clk = ~clk;

    irq_ctrl #(.N_SRC(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_src (irq_src),
        .byteen  (byteen),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq_out (irq_out),
        .irq_id  (irq_id),
        .irq_ack (irq_ack)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        bit          is_wr;
        logic [1:0]  r;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[14];

    task automatic push_exp(input string name, input logic [31:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] act);
        sb_t e;
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty actual=0x%0h", act);
        end else begin
            e = sb_q.pop_front();
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s actual=0x%0h required=0x%0h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
        addr   = {28'd0, a, 2'b00};
        byteen = be;
        wdata  = d;
        @(negedge clk);
        byteen = 4'h0;
        wdata  = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr   = {28'd0, a, 2'b00};
        byteen = 4'h0;
        #1;
        d = rdata;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        irq_src = '0;
        irq_ack = 1'b0;
        byteen  = 4'h0;
        wdata   = '0;
        addr    = '0;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    task automatic ack_pulse();
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
    endtask

    task automatic cfg_all_edge();
        wr(2'd1, 4'h1, 32'h3F);
        wr(2'd2, 4'h3, 32'h3F01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int          exp_ids[4];

        vecs[0]  = '{0, 2'd0, 4'h0, 32'h0,         32'h0,    "rst_pend"};
        vecs[1]  = '{0, 2'd3, 4'h0, 32'h0,         32'h0,    "rst_stat"};
        vecs[2]  = '{1, 2'd1, 4'h1, 32'hFFFF_FFFF, 32'h0,    "wr_ie_all"};
        vecs[3]  = '{0, 2'd1, 4'h0, 32'h0,         32'h3F,   "ie_width"};
        vecs[4]  = '{1, 2'd1, 4'h2, 32'h0,         32'h0,    "wr_ie_be1"};
        vecs[5]  = '{0, 2'd1, 4'h0, 32'h0,         32'h3F,   "ie_be1_ignored"};
        vecs[6]  = '{1, 2'd2, 4'h1, 32'h0000_3F01, 32'h0,    "wr_ctrl_be0"};
        vecs[7]  = '{0, 2'd2, 4'h0, 32'h0,         32'h1,    "ctrl_gie_only"};
        vecs[8]  = '{1, 2'd2, 4'h2, 32'hFFFF_FF00, 32'h0,    "wr_ctrl_be1"};
        vecs[9]  = '{0, 2'd2, 4'h0, 32'h0,         32'h3F01, "ctrl_edge"};
        vecs[10] = '{1, 2'd2, 4'h3, 32'h0,         32'h0,    "wr_ctrl_clr"};
        vecs[11] = '{0, 2'd2, 4'h0, 32'h0,         32'h0,    "ctrl_clear"};
        vecs[12] = '{1, 2'd3, 4'h1, 32'h0,         32'h0,    "eoi_in_idle"};
        vecs[13] = '{0, 2'd3, 4'h0, 32'h0,         32'h0,    "eoi_idle_ignored"};

`ifdef IRQ_ROTATE_EN
        exp_ids = '{1, 3, 1, 3};
`else
        exp_ids = '{1, 1, 1, 1};
`endif

        // Reset state while reset is held.
        reset = 1'b1; irq_src = '0; irq_ack = 1'b0; byteen = 4'h0; wdata = '0; addr = '0;
        push_exp("rst_irq_out", 32'd0);
        push_exp("rst_irq_id", 32'd0);
        #1;
        pop_cmp(32'(irq_out));
        pop_cmp(32'(irq_id));
        for (int a = 0; a < 4; a++) begin
            push_exp($sformatf("rst_rdata_%0d", a), 32'h0);
            rd(2'(a), d);
            pop_cmp(d);
        end
        do_reset();

        // Register access vectors.
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_wr) begin
                wr(vecs[i].r, vecs[i].be, vecs[i].wd);
            end else begin
                push_exp(vecs[i].name, vecs[i].exp);
                rd(vecs[i].r, d);
                pop_cmp(d);
            end
        end

        // Single edge pulse on source 2: latency, ack, EOI, stray ack.
        do_reset();
        cfg_all_edge();
        irq_src = 6'b000100;
        push_exp("s1_out_k1", 32'd0);
        push_exp("s1_pend_k1", 32'h04);
        push_exp("s1_out_k2", 32'd1);
        push_exp("s1_id", 32'd2);
        step(1);
        irq_src = '0;
        step(1);
        pop_cmp(32'(irq_out));
        rd(2'd0, d);
        pop_cmp(d);
        step(1);
        pop_cmp(32'(irq_out));
        pop_cmp(32'(irq_id));
        push_exp("s1_ack_out", 32'd0);
        push_exp("s1_ack_stat", 32'h202);
        push_exp("s1_ack_pend", 32'h0);
        ack_pulse();
        pop_cmp(32'(irq_out));
        rd(2'd3, d);
        pop_cmp(d);
        rd(2'd0, d);
        pop_cmp(d);
        push_exp("s1_eoi_state", 32'd0);
        wr(2'd3, 4'h1, 32'h0);
        rd(2'd3, d);
        pop_cmp((d >> 8) & 32'h3);
        push_exp("s1_stray_ack_state", 32'd0);
        ack_pulse();
        rd(2'd3, d);
        pop_cmp((d >> 8) & 32'h3);

        // Sources 4 and 1 together: priority, EOI outside SERVICE, re-request.
        do_reset();
        cfg_all_edge();
        irq_src = 6'b010010;
        push_exp("s2_out", 32'd1);
        push_exp("s2_id", 32'd1);
        step(1);
        irq_src = '0;
        step(2);
        pop_cmp(32'(irq_out));
        pop_cmp(32'(irq_id));
        push_exp("s2_eoi_in_req", 32'd1);
        wr(2'd3, 4'h1, 32'h0);
        pop_cmp(32'(irq_out));
        push_exp("s2_ack_stat", 32'h201);
        ack_pulse();
        rd(2'd3, d);
        pop_cmp(d);
        push_exp("s2_idle_out", 32'd0);
        push_exp("s2_rereq_out", 32'd1);
        push_exp("s2_rereq_id", 32'd4);
        wr(2'd3, 4'h1, 32'h0);
        pop_cmp(32'(irq_out));
        step(1);
        pop_cmp(32'(irq_out));
        pop_cmp(32'(irq_id));

        // Mask source 3 while requesting, then unmask.
        do_reset();
        cfg_all_edge();
        irq_src = 6'b001000;
        push_exp("s3_id", 32'd3);
        step(1);
        irq_src = '0;
        step(2);
        pop_cmp(32'(irq_id));
        push_exp("s3_out_hold", 32'd1);
        push_exp("s3_out_drop", 32'd0);
        push_exp("s3_state_idle", 32'd0);
        push_exp("s3_pend_kept", 32'h08);
        wr(2'd1, 4'h1, 32'h37);
        pop_cmp(32'(irq_out));
        step(1);
        pop_cmp(32'(irq_out));
        rd(2'd3, d);
        pop_cmp((d >> 8) & 32'h3);
        rd(2'd0, d);
        pop_cmp(d);
        push_exp("s3_unmask_out0", 32'd0);
        push_exp("s3_unmask_out1", 32'd1);
        push_exp("s3_unmask_id", 32'd3);
        wr(2'd1, 4'h1, 32'h3F);
        pop_cmp(32'(irq_out));
        step(1);
        pop_cmp(32'(irq_out));
        pop_cmp(32'(irq_id));

        // Level mode on source 0: W1C ignored, drop seen two edges later.
        do_reset();
        wr(2'd1, 4'h1, 32'h3F);
        wr(2'd2, 4'h3, 32'h0001);
        irq_src = 6'b000001;
        push_exp("s4_level_pend", 32'h1);
        push_exp("s4_w1c_ignored", 32'h1);
        step(2);
        rd(2'd0, d);
        pop_cmp(d);
        wr(2'd0, 4'h1, 32'h3F);
        rd(2'd0, d);
        pop_cmp(d);
        irq_src = '0;
        push_exp("s4_drop_1", 32'h1);
        push_exp("s4_drop_2", 32'h0);
        step(1);
        rd(2'd0, d);
        pop_cmp(d);
        step(1);
        rd(2'd0, d);
        pop_cmp(d);

        // Asynchronous reset mid-SERVICE, checked before the next rising edge.
        do_reset();
        cfg_all_edge();
        irq_src = 6'b000100;
        step(1);
        irq_src = '0;
        step(2);
        ack_pulse();
        push_exp("s5_in_service", 32'd2);
        rd(2'd3, d);
        pop_cmp((d >> 8) & 32'h3);
        @(posedge clk);
        #2;
        reset = 1'b1;
        push_exp("s5_rst_irq_out", 32'd0);
        push_exp("s5_rst_irq_id", 32'd0);
        #1;
        pop_cmp(32'(irq_out));
        pop_cmp(32'(irq_id));
        for (int a = 0; a < 4; a++) begin
            push_exp($sformatf("s5_rst_rdata_%0d", a), 32'h0);
            addr = 32'(a) << 2;
            #1;
            pop_cmp(rdata);
        end
        @(negedge clk);
        reset = 1'b0;

        // Level sources 1 and 3 held: priority order across repeated ack/EOI.
        do_reset();
        wr(2'd1, 4'h1, 32'h3F);
        wr(2'd2, 4'h3, 32'h0001);
        irq_src = 6'b001010;
        for (int j = 0; j < 4; j++) begin
            push_exp($sformatf("s6_id_round_%0d", j), 32'(exp_ids[j]));
            for (int t = 0; t < 10 && !irq_out; t++) step(1);
            if (!irq_out) begin
                void'(sb_q.pop_front());
                n_tests++;
                n_fail++;
                $display("FAIL s6_wait_round_%0d actual=irq_out_low required=irq_out_high", j);
            end else begin
                pop_cmp(32'(irq_id));
            end
            ack_pulse();
            if (j == 0) begin
`ifdef IRQ_ROTATE_EN
                push_exp("s6_last_id", 32'd1);
`else
                push_exp("s6_last_id", 32'd0);
`endif
                rd(2'd3, d);
                pop_cmp((d >> 16) & 32'h7);
            end
            wr(2'd3, 4'h1, 32'h0);
        end
        irq_src = '0;

        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover actual=%0d required=0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
